// File: rtl/rxuart.sv
// 8N1 UART receiver: two-flop synchronizer, half-bit start check, mid-bit data sampling.
// Emits one-cycle o_wr (good byte) or o_frame_err (stop bit low) strobes.
module rxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam logic [23:0] HALF        = CLOCKS_PER_BAUD >> 1;
  localparam logic [23:0] HALF_RELOAD = HALF - 24'd1;
  localparam logic [23:0] FULL_RELOAD = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state, state_n;
  logic [1:0]  sync;
  logic        rx_s;
  logic [23:0] cnt, cnt_n;
  logic [2:0]  bits, bits_n;
  logic [7:0]  sreg, sreg_n, data_n;
  logic        wr_n, ferr_n, tick;

  assign rx_s   = sync[1];
  assign o_busy = (state != IDLE);
  assign tick   = (cnt == 24'd0) && (state inside {START, DATA, STOP});

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync        <= 2'b11;
      state       <= IDLE;
      cnt         <= '0;
      bits        <= '0;
      sreg        <= '0;
      o_data      <= '0;
      o_wr        <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync        <= {sync[0], i_uart_rx};
      state       <= state_n;
      cnt         <= cnt_n;
      bits        <= bits_n;
      sreg        <= sreg_n;
      o_data      <= data_n;
      o_wr        <= wr_n;
      o_frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != 24'd0) ? cnt - 24'd1 : cnt;
    bits_n  = bits;
    sreg_n  = sreg;
    data_n  = o_data;
    wr_n    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = HALF_RELOAD;
      end
      START: if (tick) begin
        // A start bit that is high again at mid-bit is a glitch.
        if (!rx_s) begin
          state_n = DATA;
          bits_n  = 3'd0;
          cnt_n   = FULL_RELOAD;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: if (tick) begin
        sreg_n = {rx_s, sreg[7:1]};
        bits_n = bits + 3'd1;
        cnt_n  = FULL_RELOAD;
        if (bits == 3'd7) state_n = STOP;
      end
      STOP: if (tick) begin
        if (rx_s) begin
          wr_n    = 1'b1;
          data_n  = sreg;
          state_n = IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
